shift_sequencer: RTL and testbench

- Iterative shift controller for the EX stage of the RV32I pipeline.
- Executes SLL/SRL/SRA and SLLI/SRLI/SRAI over several cycles, shifting STEP bits per cycle, instead of using a full 32-bit barrel shifter.
- Accepts one request at a time over a valid/ready handshake and returns the result over a valid/ready handshake.
- The pipeline controller uses req_ready/busy to stall ID/EX and flush to kill an in-flight shift on redirect.

---
 rtl/shift_sequencer_pkg.sv | 20 ++
 rtl/shift_sequencer_step.sv | 24 ++
 rtl/shift_sequencer.sv | 122 ++++++++++++
 tb/tb_shift_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types and decode helper for the iterative shift sequencer.
// Funct3 encodings mirror the RV32I RTYPE shift encodings.
package shift_sequencer_pkg;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA, SH_ILL} shift_op_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;

    function automatic shift_op_t decode_shift(input logic [2:0] funct3, input logic arith);
        shift_op_t op;
        op = SH_ILL;
        if (funct3 == F3_SLL && !arith)          op = SH_SLL;
        else if (funct3 == F3_SRL_SRA && !arith) op = SH_SRL;
        else if (funct3 == F3_SRL_SRA && arith)  op = SH_SRA;
        return op;
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational single-step shifter: shifts value_i by k_i bits according to op_i.
// SRA relies on the working MSB still holding the operand's original sign bit.
module shift_sequencer_step
    import shift_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] value_i,
    input  shift_op_t       op_i,
    input  logic [4:0]      k_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = value_i;
        case (op_i)
            SH_SLL:  result_o = value_i << k_i;
            SH_SRL:  result_o = value_i >> k_i;
            SH_SRA:  result_o = $signed(value_i) >>> k_i;
            default: result_o = value_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative SLL/SRL/SRA unit: shifts up to STEP bits per cycle, valid/ready on both sides.
// A request transfers when req_valid & req_ready & !flush; a response when resp_valid & resp_ready & !flush.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic            req_arith,
    input  logic [XLEN-1:0] req_operand,
    input  logic [4:0]      req_shamt,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_err,
    output logic            busy
);

    localparam logic [4:0] STEP_K = 5'(STEP);

    shift_state_t    state_q;
    shift_op_t       op_q;
    shift_op_t       req_op;
    logic [XLEN-1:0] work_q;
    logic [XLEN-1:0] work_d;
    logic [4:0]      remaining_q;
    logic [4:0]      step_k;
    logic            err_q;
    logic            resp_valid_q;
    logic            req_ready_q;
    logic            busy_q;

    assign req_op = decode_shift(req_funct3, req_arith);
    // The final step may be shorter than STEP when shamt is not a multiple of it.
    assign step_k = (remaining_q < STEP_K) ? remaining_q : STEP_K;

    shift_sequencer_step #(.XLEN(XLEN)) u_step (
        .value_i  (work_q),
        .op_i     (op_q),
        .k_i      (step_k),
        .result_o (work_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= SH_SLL;
            work_q       <= '0;
            remaining_q  <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else if (flush) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        remaining_q <= req_shamt;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_op == SH_ILL) begin
                            work_q       <= '0;
                            err_q        <= 1'b1;
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                        end else if (req_shamt == 5'd0) begin
                            work_q       <= req_operand;
                            err_q        <= 1'b0;
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                        end else begin
                            work_q  <= req_operand;
                            err_q   <= 1'b0;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_q      <= work_d;
                    remaining_q <= remaining_q - step_k;
                    if (remaining_q == step_k) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = work_q;
    assign resp_err    = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with STEP=4: expected responses queue up at issue
// and a negedge monitor pops them on every completed response handshake.
module tb_shift_sequencer;

    localparam int XLEN = 32;
    localparam int STEP = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic            req_arith;
    logic [XLEN-1:0] req_operand;
    logic [4:0]      req_shamt;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            resp_err;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [XLEN:0] exp_q[$];
    logic [XLEN:0] mon_exp;

    shift_sequencer #(.XLEN(XLEN), .STEP(STEP)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_arith   (req_arith),
        .req_operand (req_operand),
        .req_shamt   (req_shamt),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [XLEN:0] act, input logic [XLEN:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got {err,result}=0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && !flush && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got {err,result}=0x%0h expected no response",
                         {resp_err, resp_result});
            end else begin
                mon_exp = exp_q.pop_front();
                check_word("resp", {resp_err, resp_result}, mon_exp);
            end
        end
    end

    // driver tasks
    task automatic junk_req();
        req_funct3  = 3'($urandom_range(0, 7));
        req_arith   = 1'($urandom_range(0, 1));
        req_operand = $urandom;
        req_shamt   = 5'($urandom_range(0, 31));
    endtask

    // Returns #1 after the accept edge, i.e. in cycle T+1.
    task automatic issue(input logic [2:0] f3, input logic ar, input logic [XLEN-1:0] op,
                         input logic [4:0] sh);
        @(posedge clk); #1;
        req_valid   = 1'b1;
        req_funct3  = f3;
        req_arith   = ar;
        req_operand = op;
        req_shamt   = sh;
        @(negedge clk);
        check_bit("req_ready_at_accept", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        junk_req();
    endtask

    task automatic do_req(input logic [2:0] f3, input logic ar, input logic [XLEN-1:0] op,
                          input logic [4:0] sh, input logic [XLEN-1:0] exp_res,
                          input logic exp_err, input int exp_lat, input int hold);
        int n;
        resp_ready = (hold == 0);
        issue(f3, ar, op, sh);
        exp_q.push_back({exp_err, exp_res});
        n = 1;
        @(negedge clk);
        while (!resp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_bit("resp_valid_seen", resp_valid, 1'b1);
        check_int("latency", n, exp_lat);
        check_bit("req_ready_in_done", req_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_valid   = 1'b1;
            req_funct3  = 3'b001;
            req_arith   = 1'b0;
            req_operand = $urandom;
            req_shamt   = 5'd1;
            @(negedge clk);
            check_bit("bp_valid", resp_valid, 1'b1);
            check_word("bp_result", {resp_err, resp_result}, {exp_err, exp_res});
            check_bit("bp_req_ready", req_ready, 1'b0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("resp_valid_after_hs", resp_valid, 1'b0);
        check_bit("req_ready_after_hs", req_ready, 1'b1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_bit(name, resp_valid, 1'b0);
        end
    endtask

    task automatic check_reset_outputs();
        check_bit("rst_req_ready", req_ready, 1'b1);
        check_bit("rst_resp_valid", resp_valid, 1'b0);
        check_word("rst_result", {resp_err, resp_result}, '0);
        check_bit("rst_busy", busy, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        junk_req();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // functional vectors (latency = 1 + ceil(shamt/4), illegal or shamt 0 = 1)
        do_req(3'b001, 1'b0, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 2, 0);
        do_req(3'b101, 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 9, 0);
        do_req(3'b101, 1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 9, 0);
        do_req(3'b101, 1'b0, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1, 0);
        do_req(3'b000, 1'b0, 32'h1234_5678, 5'd7,  32'h0000_0000, 1'b1, 1, 0);
        do_req(3'b001, 1'b1, 32'h0000_FFFF, 5'd3,  32'h0000_0000, 1'b1, 1, 0);
        do_req(3'b101, 1'b1, 32'h8765_4321, 5'd5,  32'hFC3B_2A19, 1'b0, 3, 0);
        do_req(3'b101, 1'b1, 32'h7000_0000, 5'd3,  32'h0E00_0000, 1'b0, 2, 0);
        do_req(3'b101, 1'b0, 32'hF000_0000, 5'd6,  32'h03C0_0000, 1'b0, 3, 0);
        do_req(3'b101, 1'b1, 32'h8000_0000, 5'd16, 32'hFFFF_8000, 1'b0, 5, 0);
        do_req(3'b001, 1'b0, 32'h8000_0001, 5'd31, 32'h8000_0000, 1'b0, 9, 0);

        // backpressure with a competing request
        do_req(3'b001, 1'b0, 32'h0000_000F, 5'd2, 32'h0000_003C, 1'b0, 2, 5);

        // flush during SHIFT (shamt 10 would complete at T+4)
        resp_ready = 1'b1;
        issue(3'b001, 1'b0, 32'h0000_0001, 5'd10);
        @(negedge clk);
        check_bit("flush_busy_before", busy, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_bit("flush_shift_busy", busy, 1'b0);
        check_bit("flush_shift_req_ready", req_ready, 1'b1);
        expect_quiet("flush_shift_quiet", 6);
        do_req(3'b001, 1'b0, 32'h0000_0001, 5'd10, 32'h0000_0400, 1'b0, 4, 0);

        // flush beats resp_ready in DONE
        issue(3'b101, 1'b0, 32'h0000_0055, 5'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_bit("flush_done_valid", resp_valid, 1'b0);
        check_bit("flush_done_req_ready", req_ready, 1'b1);
        check_bit("flush_done_busy", busy, 1'b0);

        // reset in the middle of a long shift
        issue(3'b101, 1'b1, 32'h8000_0000, 5'd20);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        expect_quiet("reset_quiet", 8);

        // flush together with req_valid in IDLE
        @(posedge clk); #1;
        req_valid   = 1'b1;
        req_funct3  = 3'b001;
        req_arith   = 1'b0;
        req_operand = 32'h0000_0003;
        req_shamt   = 5'd3;
        flush       = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check_bit("flush_idle_busy", busy, 1'b0);
        check_bit("flush_idle_req_ready", req_ready, 1'b1);
        expect_quiet("flush_idle_quiet", 5);

        do_req(3'b101, 1'b1, 32'hC000_0000, 5'd1, 32'hE000_0000, 1'b0, 2, 0);

        repeat (3) @(negedge clk);
        check_int("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
